// File: rtl/refill_alloc_pkg.sv
// rtl/refill_alloc_pkg.sv - shared types and parameter checks for the refill way allocator
package refill_alloc_pkg;

    // Allocation flow: wait for a miss, hold the chosen way until the refill
    // engine takes it, then wait for the line to complete.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALLOC  = 2'd1,
        REFILL = 2'd2
    } alloc_state_e;

    localparam int unsigned MIN_WAYS = 2;
    localparam int unsigned MAX_WAYS = 16;

    // Way count must be a power of two so the binary way index covers
    // exactly the way set.
    function automatic bit nr_ways_legal(input int unsigned nr_ways);
        return (nr_ways >= MIN_WAYS) && (nr_ways <= MAX_WAYS) &&
               ((nr_ways & (nr_ways - 1)) == 0);
    endfunction

endpackage

// File: rtl/lzc.sv
// rtl/lzc.sv - leading/trailing zero counter
// Ports:
//   in_i    : vector to search
//   cnt_o   : zero count from the LSB (MODE=0) or MSB (MODE=1); index of first set bit
//   empty_o : no bit of in_i is set
module lzc #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MODE       = 1'b0,
    parameter int unsigned CNT_WIDTH  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    logic found;

    always_comb begin
        cnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!found && in_i[MODE ? (int'(WIDTH) - 1 - i) : i]) begin
                found = 1'b1;
                cnt_o = CNT_WIDTH'(i);
            end
        end
        empty_o = ~found;
    end

endmodule

// File: rtl/refill_way_alloc.sv
// rtl/refill_way_alloc.sv - cache refill victim way allocator with eviction counter
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   flush_i                  : abort any allocation in progress
//   req_valid_i, req_ready_o : refill request handshake from the miss handler
//   way_valid_i              : valid bits of the indexed set, sampled on acceptance
//   lfsr_way_bin_i, lfsr_en_o: pseudo-random way and its advance strobe
//   alloc_valid_o/ready_i    : allocated way handshake towards the refill engine
//   alloc_way_oh_o/bin_o     : allocated way, one-hot and binary
//   alloc_evict_o            : allocated way holds valid data being replaced
//   refill_done_i            : refill engine finished the line
//   evict_cnt_o              : saturating count of completed evicting refills
module refill_way_alloc
    import refill_alloc_pkg::*;
#(
    parameter int unsigned NR_WAYS = 4,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned WAY_W  = $clog2(NR_WAYS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [NR_WAYS-1:0] way_valid_i,
    input  logic [WAY_W-1:0]   lfsr_way_bin_i,
    output logic               lfsr_en_o,
    output logic               alloc_valid_o,
    input  logic               alloc_ready_i,
    output logic [NR_WAYS-1:0] alloc_way_oh_o,
    output logic [WAY_W-1:0]   alloc_way_bin_o,
    output logic               alloc_evict_o,
    input  logic               refill_done_i,
    output logic [CNT_W-1:0]   evict_cnt_o
);

    if (!nr_ways_legal(NR_WAYS)) begin : g_bad_ways
        $error("refill_way_alloc: NR_WAYS must be a power of two in 2..16");
    end

    alloc_state_e     state_q, state_d;
    logic [WAY_W-1:0] way_q;
    logic             evict_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WAY_W-1:0] first_invalid;
    logic             all_valid;
    logic             accept;
    logic             cnt_inc;

    // Trailing-zero count of the invalid mask is the lowest invalid way;
    // an empty mask means every way is occupied.
    lzc #(
        .WIDTH (NR_WAYS),
        .MODE  (1'b0)
    ) i_first_invalid (
        .in_i    (~way_valid_i),
        .cnt_o   (first_invalid),
        .empty_o (all_valid)
    );

    assign req_ready_o = (state_q == IDLE) & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    // State already reads IDLE while reset is held, so gate the strobe
    // with reset to keep the upstream LFSR frozen.
    assign lfsr_en_o   = accept & all_valid & rst_ni;

    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ALLOC;
            end
            ALLOC: begin
                if (flush_i)            state_d = IDLE;
                else if (alloc_ready_i) state_d = REFILL;
            end
            REFILL: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (refill_done_i) begin
                    state_d = IDLE;
                    cnt_inc = evict_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            way_q   <= '0;
            evict_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                way_q   <= all_valid ? lfsr_way_bin_i : first_invalid;
                evict_q <= all_valid;
            end
            if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign alloc_valid_o   = (state_q == ALLOC);
    assign alloc_way_bin_o = way_q;
    assign alloc_way_oh_o  = NR_WAYS'(1) << way_q;
    assign alloc_evict_o   = evict_q;
    assign evict_cnt_o     = cnt_q;

endmodule

// File: doc/refill_way_alloc.md
REFILL_WAY_ALLOC -- requirements
Module: refill_way_alloc

Interface
REQ-001 Parameter NR_WAYS, default 4, SHALL set the number of cache ways; legal values are powers of two from 2 to 16.
REQ-002 Parameter CNT_W, default 16, SHALL set the eviction counter width.
REQ-003 clk_i  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 flush_i  input  1  SHALL abort any allocation in progress.
REQ-006 req_valid_i  input  1  SHALL carry the miss handler's refill request.
REQ-007 req_ready_o  output  1  SHALL signal that a request is accepted this cycle.
REQ-008 way_valid_i  input  NR_WAYS  SHALL carry the valid bits of the indexed set, sampled on acceptance.
REQ-009 lfsr_way_bin_i  input  $clog2(NR_WAYS)  SHALL carry the pseudo-random way from the upstream 16-bit LFSR.
REQ-010 lfsr_en_o  output  1  SHALL advance the upstream LFSR.
REQ-011 alloc_valid_o  output  1  SHALL mark the allocated way as valid.
REQ-012 alloc_ready_i  input  1  SHALL carry the refill engine's acceptance of the allocated way.
REQ-013 alloc_way_oh_o  output  NR_WAYS  SHALL give the allocated way as one-hot.
REQ-014 alloc_way_bin_o  output  $clog2(NR_WAYS)  SHALL give the allocated way as binary.
REQ-015 alloc_evict_o  output  1  SHALL mark the allocated way as holding valid data that is being replaced.
REQ-016 refill_done_i  input  1  SHALL signal that the refill engine has finished the line.
REQ-017 evict_cnt_o  output  CNT_W  SHALL count completed evicting refills.

Function
REQ-018 The FSM SHALL have three states: IDLE, ALLOC and REFILL.
REQ-019 req_ready_o SHALL equal (state==IDLE) & ~flush_i.
REQ-020 Acceptance (req_valid_i & req_ready_o) SHALL register the way and move to ALLOC on the next edge.
REQ-021 Victim choice at acceptance: if any way_valid_i bit is 0, the lowest-index invalid way is taken with evict=0; otherwise the way is lfsr_way_bin_i with evict=1.
REQ-022 lfsr_en_o SHALL be high, combinationally, only in an acceptance cycle in which all ways are valid; at all other times it is 0.
REQ-023 alloc_valid_o SHALL be 1 exactly while in ALLOC; way outputs and alloc_evict_o SHALL stay stable from acceptance until the return to IDLE.
REQ-024 In ALLOC, alloc_ready_i=1 SHALL move the FSM to REFILL.
REQ-025 In REFILL, refill_done_i=1 SHALL move the FSM to IDLE and increment evict_cnt_o if the registered evict flag is 1.
REQ-026 Acceptance-to-alloc_valid_o latency SHALL be 1 cycle; back-to-back requests SHALL be spaced at least 3 cycles apart (IDLE, ALLOC, REFILL).
REQ-027 refill_done_i SHALL be ignored outside REFILL; alloc_ready_i SHALL be ignored outside ALLOC.
REQ-028 flush_i in ALLOC or REFILL SHALL force IDLE on the next edge, with no counter update; flush takes priority over a simultaneous refill_done_i.
REQ-029 evict_cnt_o SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-030 alloc_way_oh_o SHALL always be the one-hot decode of alloc_way_bin_o.

Reset
REQ-031 Reset SHALL set the state to IDLE, the way register to 0 (alloc_way_oh_o = 1), the evict flag to 0 and evict_cnt_o to 0.
REQ-032 alloc_valid_o and lfsr_en_o SHALL be 0 during reset.
REQ-033 Reset asserted mid-ALLOC or mid-REFILL SHALL drop alloc_valid_o immediately and discard the allocation.

Structure
REQ-034 The FSM state enum and the NR_WAYS legality check SHALL live in shared package refill_alloc_pkg.
REQ-035 The first-invalid-way search SHALL instantiate the common_cells lzc sub-module (trailing-zero mode) on ~way_valid_i.
REQ-036 The block SHALL contain no memories; all state SHALL be in flops.

Verification
REQ-037 way_valid_i=4'b1011, request accepted -> one cycle later alloc_valid_o=1, alloc_way_bin_o=2, alloc_way_oh_o=4'b0100, alloc_evict_o=0, lfsr_en_o stays 0.
REQ-038 way_valid_i=4'b1111, lfsr_way_bin_i=3 -> lfsr_en_o=1 in the acceptance cycle only; alloc_way_bin_o=3, alloc_evict_o=1; after refill_done_i, evict_cnt_o=1.
REQ-039 alloc_ready_i held 0 for 5 cycles -> alloc_valid_o stays 1 and the way stays stable; req_ready_o stays 0 until one cycle after refill_done_i.
REQ-040 flush_i and refill_done_i high together in REFILL on an evicting refill -> next state IDLE, evict_cnt_o unchanged.
REQ-041 evict_cnt_o preloaded to 16'hFFFF via 65535 evictions (or force), then one more eviction -> evict_cnt_o remains 16'hFFFF.
REQ-042 rst_ni pulsed low asynchronously mid-ALLOC -> alloc_valid_o=0 before the next clock edge; all outputs at their reset values.
